// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//   Shared types and constants for the multicycle control unit:
//   FSM state encoding, opcode-class encoding, opcode values, ALU operation
//   codes, fault codes, the registered strobe bundle and the opcode classifier.
// ----------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH_MAR, S_FETCH_RD, S_FETCH_IR, S_DECODE, S_EXEC, S_ADDR,
      S_MEM_RD, S_MEM_WR, S_WB, S_BR, S_JMP, S_FAULT
   } state_e;

   typedef enum logic [3:0] {
      C_NONE, C_RALU, C_SPEC2, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
   } op_class_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_CLZ   = 6'b011100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BEQZ  = 6'b000001;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU_FUNCT tells the ALU to decode the instruction's funct field itself.
   localparam logic [5:0] ALU_FUNCT = 6'h00;
   localparam logic [5:0] ALU_ADD   = 6'h20;
   localparam logic [5:0] ALU_ADDU  = 6'h21;
   localparam logic [5:0] ALU_SUB   = 6'h22;
   localparam logic [5:0] ALU_NOP   = 6'h3F;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   // rd_phase / br_phase mark states whose strobes are qualified by moc / br_cond.
   typedef struct packed {
      logic       mar_load;
      logic       ir_load;
      logic       pc_load;
      logic       mem_en;
      logic       mem_rw;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       flag_load;
      logic       jump;
      logic       branch;
      logic       unsign;
      logic       rd_phase;
      logic       br_phase;
      logic [1:0] alu_src;
      logic [5:0] alu_code;
   } strobes_t;

   localparam strobes_t IDLE_STROBES = '{alu_src: 2'b11, alu_code: ALU_NOP, default: 1'b0};

   function automatic op_class_e classify(input logic [5:0] op);
      case (op)
         OP_RTYPE:                          return C_RALU;
         OP_CLZ:                            return C_SPEC2;
         OP_ADDI, OP_ADDIU:                 return C_IALU;
         OP_LW, OP_LB, OP_LBU:              return C_LOAD;
         OP_SW, OP_SB:                      return C_STORE;
         OP_BEQ, OP_BEQZ, OP_BLEZ, OP_BGTZ: return C_BRANCH;
         OP_J:                              return C_JUMP;
         default:                           return C_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
//   Counts cycles spent waiting for memory-operation-complete.
//   clk, reset (async active-low), clr (hold count at zero),
//   en (a cycle spent waiting: memory state with moc low),
//   timeout (this waiting cycle is the MEM_TIMEOUT-th one; never when
//   MEM_TIMEOUT = 0).
// ----------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int WAIT_W      = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   logic [WAIT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   // Fires on the cycle whose increment would make the count reach MEM_TIMEOUT,
   // so the FSM leaves after exactly MEM_TIMEOUT waiting cycles. en already
   // excludes moc, which makes a completing access win over the timeout.
   assign timeout = (MEM_TIMEOUT != 0) && en && (cnt == WAIT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Multicycle MIPS-subset control unit (fetch/decode/execute/memory/writeback).
//   Inputs : clk, reset (async active-low), opcode (IR[31:26]), moc (memory
//            op complete), br_cond (branch condition).
//   Outputs: datapath strobes mar_load, mdr_load, ir_load, pc_load, mem_en,
//            mem_rw, reg_write, reg_dst, mem_to_reg, flag_load, jump, branch,
//            unsign, alu_src, alu_code; sticky fault and fault_code.
//   Build option CTRL_PERF_CNT_EN adds the retired-instruction counter output
//   retired (CNT_W bits).
// ----------------------------------------------------------------------------
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALU_CODE_W  = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter int WAIT_W      = 4
`ifdef CTRL_PERF_CNT_EN
   ,
   parameter int CNT_W       = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [OPCODE_W-1:0]   opcode,
   input  logic                  moc,
   input  logic                  br_cond,
   output logic                  mar_load,
   output logic                  mdr_load,
   output logic                  ir_load,
   output logic                  pc_load,
   output logic                  mem_en,
   output logic                  mem_rw,
   output logic                  reg_write,
   output logic                  reg_dst,
   output logic                  mem_to_reg,
   output logic                  flag_load,
   output logic                  jump,
   output logic                  branch,
   output logic                  unsign,
   output logic [1:0]            alu_src,
   output logic [ALU_CODE_W-1:0] alu_code,
   output logic                  fault,
   output logic [1:0]            fault_code
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      retired
`endif
);

   state_e    st, nxt;
   op_class_e cls_q, cls_d;
   logic      uns_q, uns_d;
   strobes_t  q;
   logic      in_mem, tmo;

   // Strobes for the state being entered, so they are registered alongside it.
   function automatic strobes_t decode_strobes(input state_e s, input op_class_e c,
                                               input logic uns);
      strobes_t o;
      o = IDLE_STROBES;
      case (s)
         S_FETCH_MAR: o.mar_load = 1'b1;
         S_FETCH_RD: begin
            o.mem_en   = 1'b1;
            o.mem_rw   = 1'b1;
            o.rd_phase = 1'b1;
         end
         S_FETCH_IR: begin
            o.ir_load  = 1'b1;
            o.pc_load  = 1'b1;
            o.alu_src  = 2'b10;   // constant 4 for PC+4
            o.alu_code = ALU_ADD;
         end
         S_EXEC: begin
            if (c == C_IALU) begin
               o.alu_src  = 2'b01;
               o.alu_code = uns ? ALU_ADDU : ALU_ADD;
               o.unsign   = uns;
            end else begin
               o.alu_src  = 2'b00;
               o.alu_code = ALU_FUNCT;
            end
         end
         S_ADDR: begin
            o.mar_load = 1'b1;
            o.alu_src  = 2'b01;
            o.alu_code = ALU_ADD;
         end
         S_MEM_RD: begin
            o.mem_en   = 1'b1;
            o.mem_rw   = 1'b1;
            o.rd_phase = 1'b1;
            o.unsign   = uns;
         end
         S_MEM_WR: o.mem_en = 1'b1;
         S_WB: begin
            o.reg_write  = 1'b1;
            o.reg_dst    = (c == C_RALU) || (c == C_SPEC2);
            o.mem_to_reg = (c == C_LOAD);
            o.unsign     = uns && (c == C_LOAD);
         end
         S_BR: begin
            o.flag_load = 1'b1;
            o.branch    = 1'b1;
            o.br_phase  = 1'b1;
            o.alu_src   = 2'b00;
            o.alu_code  = ALU_SUB;
         end
         S_JMP: begin
            o.jump    = 1'b1;
            o.pc_load = 1'b1;
         end
         default: o = IDLE_STROBES;
      endcase
      return o;
   endfunction

   // Class is taken live from opcode while in DECODE and held afterwards.
   assign cls_d  = (st == S_DECODE) ? classify(opcode[5:0]) : cls_q;
   assign uns_d  = (st == S_DECODE) ? ((opcode[5:0] == OP_ADDIU) || (opcode[5:0] == OP_LBU))
                                    : uns_q;
   assign in_mem = (st == S_FETCH_RD) || (st == S_MEM_RD) || (st == S_MEM_WR);

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .WAIT_W      (WAIT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (!in_mem),
      .en      (in_mem && !moc),
      .timeout (tmo)
   );

   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:      nxt = S_FETCH_MAR;
         S_FETCH_MAR: nxt = S_FETCH_RD;
         S_FETCH_RD:  if (moc) nxt = S_FETCH_IR; else if (tmo) nxt = S_FAULT;
         S_FETCH_IR:  nxt = S_DECODE;
         S_DECODE: begin
            case (cls_d)
               C_RALU, C_SPEC2, C_IALU: nxt = S_EXEC;
               C_LOAD, C_STORE:         nxt = S_ADDR;
               C_BRANCH:                nxt = S_BR;
               C_JUMP:                  nxt = S_JMP;
               default:                 nxt = S_FAULT;
            endcase
         end
         S_EXEC:      nxt = S_WB;
         S_ADDR:      nxt = (cls_q == C_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:    if (moc) nxt = S_WB; else if (tmo) nxt = S_FAULT;
         S_MEM_WR:    if (moc) nxt = S_FETCH_MAR; else if (tmo) nxt = S_FAULT;
         S_WB, S_BR, S_JMP: nxt = S_FETCH_MAR;
         S_FAULT:     nxt = S_FAULT;
         default:     nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st         <= S_IDLE;
         cls_q      <= C_NONE;
         uns_q      <= 1'b0;
         q          <= IDLE_STROBES;
         fault      <= 1'b0;
         fault_code <= FAULT_NONE;
      end else begin
         st <= nxt;
         if (st == S_DECODE) begin
            cls_q <= cls_d;
            uns_q <= uns_d;
         end
         q     <= decode_strobes(nxt, cls_d, uns_d);
         fault <= (nxt == S_FAULT);
         // Only DECODE faults on an illegal opcode; every other entry is a timeout.
         if ((st != S_FAULT) && (nxt == S_FAULT))
            fault_code <= (st == S_DECODE) ? FAULT_ILLEGAL : FAULT_TIMEOUT;
      end
   end

   assign mar_load   = q.mar_load;
   assign mdr_load   = q.rd_phase && moc;               // capture in the moc cycle
   assign ir_load    = q.ir_load;
   assign pc_load    = q.pc_load || (q.br_phase && br_cond);
   assign mem_en     = q.mem_en;
   assign mem_rw     = q.mem_rw;
   assign reg_write  = q.reg_write;
   assign reg_dst    = q.reg_dst;
   assign mem_to_reg = q.mem_to_reg;
   assign flag_load  = q.flag_load;
   assign jump       = q.jump;
   assign branch     = q.branch;
   assign unsign     = q.unsign;
   assign alu_src    = q.alu_src;
   assign alu_code   = (q.alu_code == ALU_NOP) ? '1 : ALU_CODE_W'(q.alu_code);

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         retired <= '0;
      else if ((nxt == S_FETCH_MAR) &&
               ((st == S_WB) || (st == S_MEM_WR) || (st == S_BR) || (st == S_JMP)))
         retired <= retired + 1'b1;
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Directed bench for multicycle_ctrl_fsm with hand-computed cycle-by-cycle
//   expectations. Inputs change on the falling edge; outputs are read 1 ns later.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'b0;
   logic       moc = 1'b0;
   logic       br_cond = 1'b0;
   logic       mar_load, mdr_load, ir_load, pc_load, mem_en, mem_rw;
   logic       reg_write, reg_dst, mem_to_reg, flag_load, jump, branch, unsign;
   logic [1:0] alu_src;
   logic [5:0] alu_code;
   logic       fault;
   logic [1:0] fault_code;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] retired;
`endif

   int n_chk = 0;
   int n_err = 0;

   multicycle_ctrl_fsm #(
      .OPCODE_W    (6),
      .ALU_CODE_W  (6),
      .MEM_TIMEOUT (15),
      .WAIT_W      (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .moc        (moc),
      .br_cond    (br_cond),
      .mar_load   (mar_load),
      .mdr_load   (mdr_load),
      .ir_load    (ir_load),
      .pc_load    (pc_load),
      .mem_en     (mem_en),
      .mem_rw     (mem_rw),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .flag_load  (flag_load),
      .jump       (jump),
      .branch     (branch),
      .unsign     (unsign),
      .alu_src    (alu_src),
      .alu_code   (alu_code),
      .fault      (fault),
      .fault_code (fault_code)
`ifdef CTRL_PERF_CNT_EN
      ,
      .retired    (retired)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One cycle: inputs for the cycle are applied at the falling edge.
   task automatic tick(input logic m, input logic b);
      @(negedge clk);
      moc     = m;
      br_cond = b;
      #1;
   endtask

   // Reset released at a falling edge; the next cycle is FETCH_MAR (cycle 1).
   task automatic rst_seq();
      reset = 1'b0;
      moc = 1'b0;
      br_cond = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic logic [12:0] strobes();
      return {mar_load, mdr_load, ir_load, pc_load, mem_en, mem_rw, reg_write,
              reg_dst, mem_to_reg, flag_load, jump, branch, unsign};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #1 reset = 1'b0;
      @(negedge clk); #1;
      check("rst_strobes", strobes(), 13'h0);
      check("rst_alu", {alu_src, alu_code}, {2'b11, 6'h3F});
      check("rst_fault", {fault, fault_code}, 3'b000);
`ifdef CTRL_PERF_CNT_EN
      check("rst_retired", retired, 0);
`endif

      // R-type, moc on first memory cycle
      opcode = 6'b000000;
      rst_seq();
      tick(1, 0); check("r_c1_mar", mar_load, 1);
      tick(1, 0); check("r_c2_fetch", {mem_en, mem_rw, mdr_load}, 3'b111);
      tick(1, 0); check("r_c3_ir", {ir_load, pc_load, alu_src}, 4'b1110);
      tick(1, 0); check("r_c4_dec", strobes(), 13'h0);
      tick(1, 0); check("r_c5_exec", {alu_src, alu_code}, {2'b00, 6'h00});
      tick(1, 0); check("r_c6_wb", {reg_write, reg_dst, mem_to_reg}, 3'b110);
      tick(1, 0); check("r_c7_mar", mar_load, 1);

      // LW with moc delayed 3 cycles in MEM_RD
      opcode = 6'b100011;
      rst_seq();
      for (int i = 1; i <= 4; i++) tick(1, 0);
      tick(1, 0); check("lw_c5_addr", {mar_load, alu_src, alu_code}, {1'b1, 2'b01, 6'h20});
      tick(0, 0); check("lw_c6_wait", {mem_en, mem_rw, mdr_load}, 3'b110);
      tick(0, 0);
      tick(0, 0); check("lw_c8_wait", {mem_en, mdr_load}, 2'b10);
      tick(1, 0); check("lw_c9_moc", {mem_en, mdr_load}, 2'b11);
      tick(1, 0); check("lw_c10_wb", {reg_write, reg_dst, mem_to_reg}, 3'b101);
      tick(1, 0); check("lw_c11_mar", mar_load, 1);

      // BEQ taken, then not taken
      opcode = 6'b000100;
      rst_seq();
      for (int i = 1; i <= 4; i++) tick(1, 0);
      tick(1, 1); check("br_taken", {flag_load, branch, pc_load, alu_code}, {3'b111, 6'h22});
      tick(1, 0); check("br_ret1", mar_load, 1);
      for (int i = 7; i <= 9; i++) tick(1, 0);
      tick(1, 0); check("br_not", {flag_load, branch, pc_load}, 3'b110);
      tick(1, 0); check("br_ret2", mar_load, 1);

      // J
      opcode = 6'b000010;
      rst_seq();
      for (int i = 1; i <= 4; i++) tick(1, 0);
      tick(1, 0); check("j_c5", {jump, pc_load, branch}, 3'b110);
      tick(1, 0); check("j_c6_mar", mar_load, 1);

      // SW
      opcode = 6'b101011;
      rst_seq();
      for (int i = 1; i <= 5; i++) tick(1, 0);
      tick(1, 0); check("sw_c6", {mem_en, mem_rw, mdr_load}, 3'b100);
      tick(1, 0); check("sw_c7_mar", {mar_load, mem_en}, 2'b10);

      // ADDIU
      opcode = 6'b001001;
      rst_seq();
      for (int i = 1; i <= 4; i++) tick(1, 0);
      tick(1, 0); check("addiu_exec", {unsign, alu_src, alu_code}, {1'b1, 2'b01, 6'h21});
      tick(1, 0); check("addiu_wb", {reg_write, reg_dst, mem_to_reg}, 3'b100);

      // Illegal opcode
      opcode = 6'b111111;
      rst_seq();
      for (int i = 1; i <= 5; i++) tick(1, 0);
      check("ill_fault", {fault, fault_code}, 3'b101);
      for (int i = 0; i < 20; i++) begin
         tick(logic'(i[0]), logic'(i[1]));
         check("ill_hold", {strobes(), fault, fault_code}, {13'h0, 3'b101});
      end

      // Fetch timeout
      opcode = 6'b000000;
      rst_seq();
      tick(0, 0);
      for (int i = 2; i <= 16; i++) tick(0, 0);
      check("to_c16", {mem_en, fault}, 2'b10);
      tick(0, 0); check("to_c17", {fault, fault_code, mem_en}, 4'b1100);

      // moc on the last allowed cycle beats the timeout
      rst_seq();
      tick(0, 0);
      for (int i = 2; i <= 15; i++) tick(0, 0);
      tick(1, 0); check("mw_c16", mdr_load, 1);
      tick(1, 0); check("mw_c17", {ir_load, fault}, 2'b10);

      // Reset in the middle of MEM_RD
      opcode = 6'b100011;
      rst_seq();
      for (int i = 1; i <= 5; i++) tick(1, 0);
      tick(0, 0); check("rm_memen", mem_en, 1);
      #2 reset = 1'b0;
      #1 check("rm_async", {mem_en, mar_load, fault}, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      tick(1, 0); check("rm_restart", mar_load, 1);

`ifdef CTRL_PERF_CNT_EN
      // Three instructions retired
      opcode = 6'b000000;
      rst_seq();
      for (int i = 1; i <= 6; i++) tick(1, 0);
      opcode = 6'b000010;
      for (int i = 7; i <= 11; i++) tick(1, 0);
      opcode = 6'b000100;
      for (int i = 12; i <= 16; i++) tick(1, 0);
      tick(1, 0); check("perf_ret3", retired, 3);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
